// File: rtl/fifo_ctrl_16x8.sv
// FIFO controller that drives both ports of ram_dual_16x8 and turns push/pop valid/ready
// streams into RAM writes and prefetched reads, hiding the RAM's 1-cycle read latency.
module fifo_ctrl_16x8 #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [A_WIDTH:0]   count,
    output logic               full,
    output logic               empty,
    output logic               ram_wen,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic [D_WIDTH-1:0] ram_wdata,
    output logic [A_WIDTH-1:0] ram_raddr,
    input  logic [D_WIDTH-1:0] ram_rdata
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready depends only on the count register; out_valid is a register.
    localparam logic [A_WIDTH:0]   DEPTH   = {1'b1, {A_WIDTH{1'b0}}};
    localparam logic [A_WIDTH-1:0] PTR_ONE = 1;

    logic [A_WIDTH-1:0] wptr;
    logic [A_WIDTH-1:0] rptr;
    logic               push;
    logic               pop;
    logic [A_WIDTH:0]   count_after_pop;

    assign full     = (count == DEPTH);
    assign empty    = (count == '0);
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    assign ram_wen   = push;
    assign ram_waddr = wptr;
    assign ram_wdata = in_data;
    // Prefetch the next head on a pop so back-to-back pops sustain one entry per clock.
    assign ram_raddr = pop ? (rptr + PTR_ONE) : rptr;
    assign out_data  = ram_rdata;

    assign count_after_pop = count - {{A_WIDTH{1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // An entry written this edge is not readable until the next one, so the
            // pre-edge count is used; this gives the 2-clock push-to-valid latency.
            out_valid <= (count_after_pop != '0);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// Bench for fifo_ctrl_16x8 with a behavioural registered-read dual-port RAM and a
// queue-based scoreboard checking data order, count, full and empty.
module tb_fifo_ctrl_16x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ram_wen;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [3:0] ram_raddr;
    logic [7:0] ram_rdata;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         pop_cnt  = 0;

    fifo_ctrl_16x8 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: registered read returning old data on read-during-write.
    always_ff @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (count != 0 && guard < 100) begin
            step();
            guard++;
        end
        check("drain_done", {31'd0, (count == 0)}, 32'd1);
        out_ready = 1'b0;
        step();
    endtask

    // Scoreboard monitor, sampled mid-cycle with inputs stable.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("count", {27'd0, count}, exp_q.size());
            check("full",  {31'd0, full},  {31'd0, (exp_q.size() == 16)});
            check("empty", {31'd0, empty}, {31'd0, (exp_q.size() == 0)});
            check("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() != 16)});
            if (out_valid && exp_q.size() == 0)
                check("valid_when_empty", {31'd0, out_valid}, 32'd0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                pop_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    initial begin
        int pops_before;
        int guard;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Test 1: three pushes with consumer stalled
        in_valid = 1'b1; in_data = 8'h11; step();
        check("t1_ov_after1", {31'd0, out_valid}, 32'd0);
        in_data = 8'h22; step();
        check("t1_ov_after2", {31'd0, out_valid}, 32'd1);
        check("t1_head_early", {24'd0, out_data}, 32'h11);
        in_data = 8'h33; step();
        in_valid = 1'b0; step();
        check("t1_count", {27'd0, count}, 32'd3);
        check("t1_head", {24'd0, out_data}, 32'h11);
        step();
        check("t1_head_stable", {24'd0, out_data}, 32'h11);
        drain();

        // Test 2: fill, overflow attempt, ordered drain
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = i[7:0]; step();
        end
        check("t2_full", {31'd0, full}, 32'd1);
        check("t2_in_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'h99; step();
        in_valid = 1'b0;
        check("t2_count_hold", {27'd0, count}, 32'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_pop_valid", {31'd0, out_valid}, 32'd1);
            check("t2_pop_data", {24'd0, out_data}, i);
            step();
        end
        out_ready = 1'b0;
        check("t2_empty", {31'd0, empty}, 32'd1);
        check("t2_ov_off", {31'd0, out_valid}, 32'd0);
        step();

        // Test 3: 40-clock stream, pops every clock after the 2-clock latency
        pops_before = pop_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + i[7:0]; step();
        end
        in_valid = 1'b0;
        check("t3_stream_pops", pop_cnt - pops_before, 32'd38);
        drain();

        // Test 4: count=1 with simultaneous push and pop
        in_valid = 1'b1; in_data = 8'hAA; step();
        in_valid = 1'b0; step();
        check("t4_head_aa", {24'd0, out_data}, 32'hAA);
        in_valid = 1'b1; in_data = 8'hBB; out_ready = 1'b1; step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("t4_ov_gap", {31'd0, out_valid}, 32'd0);
        check("t4_count", {27'd0, count}, 32'd1);
        step();
        check("t4_ov_back", {31'd0, out_valid}, 32'd1);
        check("t4_head_bb", {24'd0, out_data}, 32'hBB);
        drain();

        // Test 5: random traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            step();
        end
        in_valid = 1'b0;
        drain();

        // Test 6: asynchronous reset with 5 entries mid-stall
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + i[7:0]; step();
        end
        in_valid = 1'b0; step(); step();
        check("t6_pre_count", {27'd0, count}, 32'd5);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_count", {27'd0, count}, 32'd0);
        check("t6_rst_empty", {31'd0, empty}, 32'd1);
        check("t6_rst_ov", {31'd0, out_valid}, 32'd0);
        step();
        rst = 1'b0;
        step();
        in_valid = 1'b1; in_data = 8'h5A; step();
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (!out_valid && guard < 10) begin
            step();
            guard++;
        end
        check("t6_ov_seen", {31'd0, out_valid}, 32'd1);
        check("t6_first_pop", {24'd0, out_data}, 32'h5A);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
